pwm_update_sequencer: RTL

//  Owns the shared PWM period counter and the duty-cycle register file for an array of SIZE PWM channels.

---
 rtl/pwm_seq_pkg.sv | 37 +++
 rtl/pwm_update_sequencer_counter.sv | 35 +++
 rtl/pwm_update_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pwm_seq_pkg.sv
// -----------------------------------------------------------------------------
// pwm_seq_pkg
//   Shared types and helpers for the PWM update sequencer slice.
//   - seq_state_e : sequencer states (APPLY is only reached in the serial build)
//   - clog2()     : ceiling log2 for sizing channel indices
//   - cnt_max()   : terminal count of a WIDTH-bit period counter
//   - DEF_WIDTH / DEF_SIZE / CNT_MAX : default geometry (8-bit counter, 8 channels)
// -----------------------------------------------------------------------------
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } seq_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SIZE  = 8;
    localparam int CNT_MAX   = 2**DEF_WIDTH - 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int cnt_max(input int width);
        return (2**width) - 1;
    endfunction

endpackage

// File: rtl/pwm_update_sequencer_counter.sv
// -----------------------------------------------------------------------------
// pwm_period_counter
//   Free-running shared PWM period counter, 0 .. 2**WIDTH-1, wrapping to 0.
//   Never stalls. wrap flags the last count of the period (cnt == CNT_MAX),
//   i.e. the cycle whose closing edge starts a new period.
// Ports
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset (counter -> 0)
//   cnt    out  WIDTH  current period count
//   wrap   out  1      cnt is at its terminal value
// -----------------------------------------------------------------------------
module pwm_period_counter
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign wrap = (cnt == MAX);

endmodule

// File: rtl/pwm_update_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_update_sequencer
//   Owns the shared PWM period counter and the duty register file for SIZE
//   PWM channels. Duty writes land in a shadow bank; a commit arms the
//   sequencer and the whole bank is applied atomically at the next period
//   boundary, so the comparator datapath never sees a mid-period change.
//
//   Build option PWM_SEQ_SERIAL_EN:
//     undefined : parallel duty_active bus, whole bank copied on the wrap edge.
//     defined   : duty_active removed; after the wrap the bank is streamed out
//                 on shift_data (shadow[SIZE-1] first, shadow[0] last), one
//                 word per cycle with shift_en, latch/upd_pulse on the last
//                 word. Requires SIZE < 2**WIDTH so streaming ends in-period.
//
// Ports
//   clk          in   1           system clock, rising edge
//   rst_n        in   1           asynchronous active-low reset
//   wr_valid     in   1           duty write request
//   wr_ready     out  1           write accepted when valid & ready (IDLE only)
//   wr_chan      in   CW          target channel; >= SIZE accepted and dropped
//   wr_duty      in   WIDTH       duty value (high time in clocks)
//   commit       in   1           request apply of shadow bank at next boundary
//   busy         out  1           commit pending or apply in progress
//   period_cnt   out  WIDTH       shared counter to comparators (pwm = cnt < duty)
//   duty_active  out  SIZE*WIDTH  active duties, channel i at [i*WIDTH +: WIDTH]
//                                 (parallel build only)
//   shift_data   out  WIDTH       streamed duty word (serial build only)
//   shift_en     out  1           shift_data valid (serial build only)
//   latch        out  1           last streamed word, latch now (serial build only)
//   upd_pulse    out  1           one-cycle strobe: new duties effective this cycle
// -----------------------------------------------------------------------------
module pwm_update_sequencer
    import pwm_seq_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int SIZE  = DEF_SIZE,
    localparam int CW    = (SIZE > 1) ? clog2(SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [CW-1:0]         wr_chan,
    input  logic [WIDTH-1:0]      wr_duty,
    input  logic                  commit,
    output logic                  busy,
    output logic [WIDTH-1:0]      period_cnt,
`ifdef PWM_SEQ_SERIAL_EN
    output logic [WIDTH-1:0]      shift_data,
    output logic                  shift_en,
    output logic                  latch,
`else
    output logic [SIZE*WIDTH-1:0] duty_active,
`endif
    output logic                  upd_pulse
);

    localparam logic [1:0]  ST_IDLE  = IDLE;
    localparam logic [1:0]  ST_ARMED = ARMED;
`ifdef PWM_SEQ_SERIAL_EN
    localparam logic [1:0]  ST_APPLY = APPLY;
`endif
    localparam logic [CW:0] SIZE_W   = (CW+1)'(SIZE);

    logic [1:0]       state;
    logic [WIDTH-1:0] shadow [SIZE];
    logic             cnt_wrap;
    logic             chan_ok;
    logic             wr_fire;

    // ---- shared period counter ----
    pwm_period_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (period_cnt),
        .wrap  (cnt_wrap)
    );

    // ---- write handshake and shadow bank ----
    // Writes are only taken while idle, which freezes the bank from the commit
    // until the apply has finished. An out-of-range channel still handshakes
    // (so the producer never stalls) but nothing is stored.
    assign wr_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign chan_ok  = ({1'b0, wr_chan} < SIZE_W);
    assign wr_fire  = wr_valid && wr_ready && chan_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_fire) begin
            shadow[wr_chan] <= wr_duty;
        end
    end

`ifdef PWM_SEQ_SERIAL_EN
    // ---- serial apply: ARMED -> APPLY at the wrap, stream SIZE words ----
    logic [CW-1:0] shift_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A commit on the terminal count arms here; the wrap on
                    // this same edge is not seen, so the apply waits a period.
                    if (commit) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (cnt_wrap) begin
                        state     <= ST_APPLY;
                        shift_idx <= CW'(SIZE - 1);
                    end
                end
                ST_APPLY: begin
                    if (shift_idx == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        shift_idx <= shift_idx - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign shift_en   = (state == ST_APPLY);
    assign shift_data = shift_en ? shadow[shift_idx] : '0;
    assign latch      = shift_en && (shift_idx == '0);
    assign upd_pulse  = latch;

`else
    // ---- parallel apply: whole bank copied on the wrap edge ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            upd_pulse   <= 1'b0;
            duty_active <= '0;
        end else begin
            upd_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A commit on the terminal count arms here; the wrap on
                    // this same edge is not seen, so the apply waits a period.
                    if (commit) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Registered strobe lands in the cnt==0 cycle, the first
                    // cycle the comparators use the new duties.
                    if (cnt_wrap) begin
                        state     <= ST_IDLE;
                        upd_pulse <= 1'b1;
                        for (int i = 0; i < SIZE; i++) begin
                            duty_active[i*WIDTH +: WIDTH] <= shadow[i];
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
`endif

endmodule
